// File: rtl/uart_pkg.sv
// Shared UART types and oversampling constants for the receive (and future transmit) path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned START_MID  = 8;

endpackage

// File: rtl/uart_rx_axis_if.sv
// AXI-Stream byte channel carrying received UART characters.
interface uart_rx_axis_if #(
  parameter int unsigned DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/uart_baud_tick.sv
// 16x oversampling tick generator; restart realigns the phase to a start-bit edge.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned BAUD_RATE = 115200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int unsigned DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int unsigned CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (restart) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (r_cnt == CNT_W'(DIV - 1)) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + CNT_W'(1);
      r_tick <= 1'b0;
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/uart_rx_axis.sv
// 8N1 UART receiver with a pending stage that frames messages by line idle (tlast).
module uart_rx_axis
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned IDLE_BITS  = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              uart_rxd,
  uart_rx_axis_if.master    rx_axis,
  output logic              frame_err,
  output logic              overrun
);

  localparam int unsigned OS_W       = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W      = $clog2(DATA_WIDTH + 1);
  localparam int unsigned IDLE_LIMIT = IDLE_BITS * OVERSAMPLE;
  localparam int unsigned IDLE_W     = $clog2(IDLE_LIMIT + 1);

  rx_state_t              r_state, w_state_nxt;
  logic [OS_W-1:0]        r_os_cnt, w_os_nxt;
  logic [BIT_W-1:0]       r_bit_cnt, w_bit_nxt;
  logic [DATA_WIDTH-1:0]  r_shift, w_shift_nxt;
  logic [1:0]             r_sync;
  logic                   r_rxd_prev;
  logic                   r_pend_valid;
  logic [DATA_WIDTH-1:0]  r_pend_data;
  logic [IDLE_W-1:0]      r_idle_cnt;
  logic                   r_tvalid, r_tlast, r_frame_err, r_overrun;
  logic [DATA_WIDTH-1:0]  r_tdata;
  logic                   w_rxd, w_fall, w_tick, w_restart, w_byte_done, w_frame_err;
  logic                   w_out_free, w_idle_hit;

  // Two-stage synchronizer; idle-high reset keeps a spurious start edge away
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync     <= 2'b11;
      r_rxd_prev <= 1'b1;
    end else begin
      r_sync     <= {r_sync[0], uart_rxd};
      r_rxd_prev <= r_sync[1];
    end
  end

  assign w_rxd  = r_sync[1];
  assign w_fall = r_rxd_prev & ~w_rxd;

  uart_baud_tick #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) u_baud_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (w_restart),
    .tick    (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_os_cnt  <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_os_cnt  <= w_os_nxt;
      r_bit_cnt <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_os_nxt    = r_os_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_restart   = 1'b0;
    w_byte_done = 1'b0;
    w_frame_err = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_fall) begin
          w_state_nxt = START;
          w_os_nxt    = '0;
          w_restart   = 1'b1;
        end
      end
      START: begin
        if (w_tick) begin
          if (r_os_cnt == OS_W'(START_MID - 1)) begin
            w_os_nxt    = '0;
            w_bit_nxt   = '0;
            w_state_nxt = w_rxd ? IDLE : DATA;
          end else begin
            w_os_nxt = r_os_cnt + OS_W'(1);
          end
        end
      end
      DATA: begin
        if (w_tick) begin
          if (r_os_cnt == OS_W'(OVERSAMPLE - 1)) begin
            w_os_nxt    = '0;
            w_shift_nxt = DATA_WIDTH'({w_rxd, r_shift} >> 1);
            w_bit_nxt   = r_bit_cnt + BIT_W'(1);
            if (r_bit_cnt == BIT_W'(DATA_WIDTH - 1)) begin
              w_state_nxt = STOP;
            end
          end else begin
            w_os_nxt = r_os_cnt + OS_W'(1);
          end
        end
      end
      STOP: begin
        if (w_tick) begin
          if (r_os_cnt == OS_W'(OVERSAMPLE - 1)) begin
            w_os_nxt = '0;
            if (w_rxd) begin
              w_byte_done = 1'b1;
              w_state_nxt = IDLE;
            end else begin
              w_frame_err = 1'b1;
              w_state_nxt = BREAK;
            end
          end else begin
            w_os_nxt = r_os_cnt + OS_W'(1);
          end
        end
      end
      BREAK: begin
        if (w_rxd) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Idle time after the last byte; any new character restarts the measurement
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle_cnt <= '0;
    end else if ((r_state != IDLE) || !r_pend_valid) begin
      r_idle_cnt <= '0;
    end else if (w_tick && !w_idle_hit) begin
      r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
    end
  end

  assign w_idle_hit = (r_idle_cnt == IDLE_W'(IDLE_LIMIT));
  assign w_out_free = ~r_tvalid | rx_axis.tready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_valid <= 1'b0;
      r_pend_data  <= '0;
      r_tvalid     <= 1'b0;
      r_tdata      <= '0;
      r_tlast      <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_frame_err <= w_frame_err;
      r_overrun   <= 1'b0;
      if (r_tvalid && rx_axis.tready) begin
        r_tvalid <= 1'b0;
      end
      if (w_byte_done) begin
        if (!r_pend_valid) begin
          r_pend_valid <= 1'b1;
          r_pend_data  <= r_shift;
        end else if (w_out_free) begin
          // A following byte proves the pending one was not the message end
          r_tvalid    <= 1'b1;
          r_tdata     <= r_pend_data;
          r_tlast     <= 1'b0;
          r_pend_data <= r_shift;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_pend_valid && w_idle_hit && w_out_free) begin
        r_tvalid     <= 1'b1;
        r_tdata      <= r_pend_data;
        r_tlast      <= 1'b1;
        r_pend_valid <= 1'b0;
      end
    end
  end

  assign rx_axis.tvalid = r_tvalid;
  assign rx_axis.tdata  = r_tdata;
  assign rx_axis.tlast  = r_tlast;
  assign frame_err      = r_frame_err;
  assign overrun        = r_overrun;

endmodule

// File: tb/tb_uart_rx_axis.sv
// Scoreboard bench for uart_rx_axis: directed UART characters, monitor-side AXI-S checking.
module tb_uart_rx_axis;
  import uart_pkg::*;

  localparam int unsigned BIT_CLKS = 32;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic uart_rxd = 1'b1;
  logic frame_err, overrun;

  uart_rx_axis_if #(.DATA_WIDTH(8)) rx_axis ();

  uart_rx_axis #(
    .DATA_WIDTH (8),
    .BAUD_RATE  (100000),
    .CLK_FREQ   (3200000),
    .IDLE_BITS  (20)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .uart_rxd  (uart_rxd),
    .rx_axis   (rx_axis.master),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  beat_t exp_q[$];
  int n_pass = 0;
  int n_total = 0;
  int n_ferr = 0;
  int n_ovr = 0;
  logic       hold = 1'b0;
  logic [7:0] hold_d;
  logic       hold_l;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Monitor: samples at negedge, i.e. the values the next posedge will see
  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      hold = 1'b0;
    end else begin
      if (frame_err) n_ferr++;
      if (overrun) n_ovr++;
      if (hold && rx_axis.tvalid) begin
        check("stable_tdata", 32'(rx_axis.tdata), 32'(hold_d));
        check("stable_tlast", 32'(rx_axis.tlast), 32'(hold_l));
      end
      if (rx_axis.tvalid && rx_axis.tready) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL extra_beat: got tdata=%0h tlast=%0b with nothing expected",
                   rx_axis.tdata, rx_axis.tlast);
        end else begin
          e = exp_q.pop_front();
          check("beat_tdata", 32'(rx_axis.tdata), 32'(e.d));
          check("beat_tlast", 32'(rx_axis.tlast), 32'(e.l));
        end
      end
      hold   = rx_axis.tvalid && !rx_axis.tready;
      hold_d = rx_axis.tdata;
      hold_l = rx_axis.tlast;
    end
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    uart_rxd = b;
    clks(BIT_CLKS);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_bit = 1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop_bit);
  endtask

  task automatic push(input logic [7:0] d, input logic l);
    beat_t b;
    b.d = d;
    b.l = l;
    exp_q.push_back(b);
  endtask

  task automatic end_test(input string name, input int ferr0, input int ovr0,
                          input int exp_ferr, input int exp_ovr);
    check({name, "_missing_beats"}, 32'(exp_q.size()), 32'd0);
    check({name, "_frame_err"}, 32'(n_ferr - ferr0), 32'(exp_ferr));
    check({name, "_overrun"}, 32'(n_ovr - ovr0), 32'(exp_ovr));
  endtask

  initial begin
    int f0, o0;
    rx_axis.tready = 1'b1;
    clks(4);
    @(negedge clk);
    check("rst_tvalid", 32'(rx_axis.tvalid), 32'd0);
    check("rst_tdata", 32'(rx_axis.tdata), 32'd0);
    check("rst_tlast", 32'(rx_axis.tlast), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_state", 32'(dut.r_state), 32'(IDLE));
    clks(1);
    rst_n = 1'b1;
    clks(BIT_CLKS * 2);

    // 1: single byte closed by idle
    f0 = n_ferr; o0 = n_ovr;
    push(8'hA5, 1'b1);
    send_byte(8'hA5);
    clks(BIT_CLKS * 25);
    end_test("t1", f0, o0, 0, 0);

    // 2: "OPEN" back-to-back
    f0 = n_ferr; o0 = n_ovr;
    push(8'h4F, 1'b0); push(8'h50, 1'b0); push(8'h45, 1'b0); push(8'h4E, 1'b1);
    send_byte(8'h4F); send_byte(8'h50); send_byte(8'h45); send_byte(8'h4E);
    clks(BIT_CLKS * 25);
    end_test("t2", f0, o0, 0, 0);

    // 3: framing error then a good byte
    f0 = n_ferr; o0 = n_ovr;
    push(8'h3C, 1'b1);
    send_byte(8'h00, 1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    uart_rxd = 1'b1;
    clks(BIT_CLKS * 3);
    send_byte(8'h3C);
    clks(BIT_CLKS * 25);
    end_test("t3", f0, o0, 1, 0);

    // 4: consumer stalled, third byte overruns
    f0 = n_ferr; o0 = n_ovr;
    rx_axis.tready = 1'b0;
    push(8'h11, 1'b0); push(8'h22, 1'b1);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    clks(BIT_CLKS * 2);
    @(negedge clk);
    check("t4_slot_valid", 32'(rx_axis.tvalid), 32'd1);
    check("t4_slot_data", 32'(rx_axis.tdata), 32'h11);
    check("t4_overrun_held", 32'(n_ovr - o0), 32'd1);
    clks(1);
    rx_axis.tready = 1'b1;
    clks(BIT_CLKS * 25);
    end_test("t4", f0, o0, 0, 1);

    // 5: short low glitch must be rejected
    f0 = n_ferr; o0 = n_ovr;
    uart_rxd = 1'b0;
    clks(6);
    uart_rxd = 1'b1;
    clks(BIT_CLKS * 2);
    @(negedge clk);
    check("t5_state", 32'(dut.r_state), 32'(IDLE));
    check("t5_tvalid", 32'(rx_axis.tvalid), 32'd0);
    clks(BIT_CLKS * 22);
    end_test("t5", f0, o0, 0, 0);

    // 6: reset in the middle of 0x7E, then 0x81
    f0 = n_ferr; o0 = n_ovr;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i == 0 ? 1'b0 : 1'b1);
    uart_rxd = 1'b1;
    clks(BIT_CLKS / 2);
    rst_n = 1'b0;
    clks(3);
    @(negedge clk);
    check("t6_rst_tvalid", 32'(rx_axis.tvalid), 32'd0);
    check("t6_rst_pend", 32'(dut.r_pend_valid), 32'd0);
    check("t6_rst_state", 32'(dut.r_state), 32'(IDLE));
    clks(1);
    rst_n = 1'b1;
    clks(BIT_CLKS * 2);
    push(8'h81, 1'b1);
    send_byte(8'h81);
    clks(BIT_CLKS * 25);
    end_test("t6", f0, o0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
